// File: rtl/lane_rhythm_ctrl.sv
// rtl/lane_rhythm_ctrl.sv - N-lane rhythm game round sequencer: clear, latch, judge, draw, wait, advance.
module lane_rhythm_ctrl #(
    parameter int LANES       = 4,
    parameter int ROWS        = 40,
    parameter int OFF_W       = 6,
    parameter int WAIT_CYCLES = 16,
    parameter int MAX_MISSES  = 3,
    parameter int SCORE_W     = 12,
    parameter int STRICT      = 0,
    parameter int LOOP        = 0,
    localparam int MISS_W     = ($clog2(MAX_MISSES + 1) < 2) ? 2 : $clog2(MAX_MISSES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LANES-1:0]   keys,
    input  logic [LANES-1:0]   note_row,
    input  logic               clr_done,
    input  logic               draw_done,
    output logic               clr_start,
    output logic               draw_start,
    output logic               row_advance,
    output logic [OFF_W-1:0]   offset,
    output logic               hit_out,
    output logic               miss_out,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] combo,
    output logic [MISS_W-1:0]  misses,
    output logic               game_over,
    output logic               song_done
);
    localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LATCH, S_JUDGE, S_DRAW, S_WAIT, S_ADVANCE, S_OVER
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LANES-1:0]  keys_q;
    logic [LANES-1:0]  note_q;
    logic [WAIT_W-1:0] wait_cnt;

    logic               note_any;
    logic               judge_hit;
    logic               judge_miss;
    logic               miss_limit;
    logic               last_row;
    logic               bonus;
    logic [SCORE_W-1:0] note_pop;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;
    logic [SCORE_W-1:0] combo_inc;
    logic [MISS_W-1:0]  misses_inc;

    // Judge datapath works only on the latched row so mid-row key bounces cannot change the verdict.
    always_comb begin
        note_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            note_pop = note_pop + SCORE_W'(note_q[i]);
        end
    end

    assign note_any   = |note_q;
    assign judge_hit  = note_any && ((keys_q & note_q) == note_q) &&
                        ((STRICT == 0) || ((keys_q & ~note_q) == '0));
    assign judge_miss = (note_any && !judge_hit) ||
                        ((STRICT != 0) && !note_any && (keys_q != '0));

    assign bonus      = (combo >= SCORE_W'(8));
    assign score_sum  = {1'b0, score} + {1'b0, note_pop} + {{SCORE_W{1'b0}}, bonus};
    assign score_sat  = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    assign combo_inc  = (&combo) ? combo : combo + SCORE_W'(1);
    assign misses_inc = misses + MISS_W'(1);
    assign miss_limit = judge_miss && (misses_inc == MISS_W'(MAX_MISSES));
    assign last_row   = (offset == OFF_W'(ROWS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_CLEAR;
            S_CLEAR:   if (clr_done) state_nxt = S_LATCH;
            S_LATCH:   state_nxt = S_JUDGE;
            S_JUDGE:   state_nxt = miss_limit ? S_OVER : S_DRAW;
            S_DRAW:    if (draw_done) state_nxt = S_WAIT;
            S_WAIT:    if (wait_cnt == '0) state_nxt = S_ADVANCE;
            S_ADVANCE: state_nxt = (last_row && (LOOP == 0)) ? S_OVER : S_LATCH;
            S_OVER:    if (start) state_nxt = S_CLEAR;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        clr_start  = (state == S_CLEAR);
        draw_start = (state == S_DRAW);
        game_over  = (state == S_OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keys_q      <= '0;
            note_q      <= '0;
            wait_cnt    <= '0;
            offset      <= '0;
            score       <= '0;
            combo       <= '0;
            misses      <= '0;
            hit_out     <= 1'b0;
            miss_out    <= 1'b0;
            row_advance <= 1'b0;
            song_done   <= 1'b0;
        end else begin
            hit_out     <= 1'b0;
            miss_out    <= 1'b0;
            row_advance <= 1'b0;
            case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        score     <= '0;
                        combo     <= '0;
                        misses    <= '0;
                        offset    <= '0;
                        song_done <= 1'b0;
                    end
                end
                S_LATCH: begin
                    keys_q <= keys;
                    note_q <= note_row;
                end
                S_JUDGE: begin
                    hit_out  <= judge_hit;
                    miss_out <= judge_miss;
                    if (judge_hit) begin
                        score <= score_sat;
                        combo <= combo_inc;
                    end else if (judge_miss) begin
                        misses <= misses_inc;
                        combo  <= '0;
                    end
                end
                S_DRAW: begin
                    if (draw_done) wait_cnt <= WAIT_W'(WAIT_CYCLES - 1);
                end
                S_WAIT: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
                end
                S_ADVANCE: begin
                    if (!last_row) begin
                        offset      <= offset + OFF_W'(1);
                        row_advance <= 1'b1;
                    end else if (LOOP != 0) begin
                        offset      <= '0;
                        row_advance <= 1'b1;
                    end else begin
                        song_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/lane_rhythm_ctrl.md
Name: lane_rhythm_ctrl

Overview:
Parametrised successor to the single-lane game sequencer: controls an N-lane rhythm game round from screen clear through per-row judge, draw and wait phases. Compares player keys against the note pattern at the judge line. Maintains score, combo and miss counters, advances the scroll offset, and ends the round on a miss limit or at song end. Sits between the key synchroniser and note ROM on one side and the VGA row drawer on the other.

Parameters:
LANES, 4, number of note lanes / keys
ROWS, 40, rows per song; offset counts 0..ROWS-1
OFF_W, 6, offset width (must satisfy 2^OFF_W >= ROWS)
WAIT_CYCLES, 16, cycles spent in WAIT per row (>=1)
MAX_MISSES, 3, miss count that ends the round (>=1)
SCORE_W, 12, score and combo width
STRICT, 0, 1 = extra keys pressed count as a miss
LOOP, 0, 1 = offset wraps and play continues; 0 = round ends at last row

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin round (sampled in IDLE/OVER only)
keys  in  LANES  synchronised key levels, 1 = pressed
note_row  in  LANES  note pattern at judge line for current offset
clr_done  in  1  screen clear complete
draw_done  in  1  row draw complete
clr_start  out  1  request screen clear (level)
draw_start  out  1  request row draw (level)
row_advance  out  1  one-cycle pulse when offset changes
offset  out  OFF_W  current row
hit_out  out  1  one-cycle pulse, row judged hit
miss_out  out  1  one-cycle pulse, row judged miss
score  out  SCORE_W  accumulated score
combo  out  SCORE_W  consecutive hits
misses  out  2..8 (clog2(MAX_MISSES+1))  miss count
game_over  out  1  round ended (level, in OVER)
song_done  out  1  round ended by reaching last row, not misses

Behaviour:
- Reset (any time, asynchronous): state IDLE; all outputs, counters and latches 0. Mid-round reset abandons the round with no further pulses.
- States: IDLE, CLEAR, LATCH, JUDGE, DRAW, WAIT, ADVANCE, OVER.
- IDLE: start=1 -> CLEAR; score, combo, misses, offset, song_done cleared on this transition.
- CLEAR: clr_start=1; clr_done=1 -> LATCH. clr_done outside CLEAR is ignored.
- LATCH: capture keys and note_row into registers (1 cycle) -> JUDGE.
- JUDGE (1 cycle, uses latched values; pulses asserted on the JUDGE->next edge, visible the cycle after JUDGE):
  - hit = note!=0 AND (keys & note)==note AND (STRICT==0 OR (keys & ~note)==0).
  - miss = (note!=0 AND !hit) OR (STRICT==1 AND note==0 AND keys!=0).
  - Empty row with no miss: no pulse, counters unchanged.
  - hit: score += popcount(note) + (combo>=8 ? 1 : 0), saturating at 2^SCORE_W-1; combo += 1, saturating.
  - miss: misses += 1; combo = 0.
  - If miss and new misses == MAX_MISSES -> OVER (song_done=0), else -> DRAW.
- DRAW: draw_start=1 until draw_done=1 -> WAIT. draw_done coincident with entry is accepted only from the next cycle.
- WAIT: internal counter loads WAIT_CYCLES-1 on entry and decrements; at 0 -> ADVANCE. Exactly WAIT_CYCLES cycles in WAIT.
- ADVANCE (1 cycle): if offset==ROWS-1: LOOP=1 -> offset=0, row_advance=1, -> LATCH; LOOP=0 -> song_done=1, -> OVER (offset holds). Otherwise offset+1, row_advance=1, -> LATCH.
- OVER: game_over=1; score, combo, misses and song_done hold. start=1 -> CLEAR with the same clears as IDLE.
- start asserted in any other state is ignored. keys and note_row are sampled only in LATCH.
- Per-row latency with no stalls: LATCH 1 + JUDGE 1 + DRAW (>=1, handshake) + WAIT WAIT_CYCLES + ADVANCE 1.

Test Plan:
- Reset, start=1, clr_done after 5 cycles -> clr_start high for exactly those cycles, then LATCH. Outputs 0 before start.
- note_row=4'b0101, keys=4'b0111, STRICT=0 -> hit_out pulse, score=2, combo=1. Same with STRICT=1 -> miss_out, misses=1, combo=0.
- Hold keys=0 against nonempty rows, MAX_MISSES=3 -> third miss gives game_over=1, song_done=0, no further draw_start. start then resets counters to 0.
- 9 consecutive 1-note hits -> score=10 (bonus on the 9th), combo=9. Also preload score near max and confirm it saturates.
- ROWS=4, LOOP=0, all rows empty -> offset sequence 0,1,2,3, three row_advance pulses, then song_done=1 and game_over=1. With LOOP=1, offset wraps 3->0 with a row_advance pulse.
- Assert reset during WAIT with score=5 -> all outputs 0 immediately (asynchronous), state IDLE, no pulses after release.
